// File: rtl/fib_write_checker_if.sv
// Snooped CPU data-memory write port: store strobe, address and data.
// memwrite is a valid-only strobe; observers are always ready, so every cycle with memwrite=1 is one store.
interface fib_write_checker_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  memwrite;
    logic [ADDR_WIDTH-1:0] adr;
    logic [WIDTH-1:0]      writedata;

    modport master (output memwrite, adr, writedata);
    modport slave  (input  memwrite, adr, writedata);
endinterface

// File: rtl/fib_write_checker.sv
// Observe-only monitor: checks CPU stores against the Fibonacci sequence at consecutive addresses
// starting at BASE_ADDR, with pass/fail counters, first-failure capture and sticky done/error/overrun.
module fib_write_checker #(
    parameter int WIDTH         = 8,
    parameter int ADDR_WIDTH    = 8,
    parameter int BASE_ADDR     = 128,
    parameter int NUM_TERMS     = 14,
    parameter int STRICT_WINDOW = 0,
    parameter int CNT_W         = $clog2(NUM_TERMS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    fib_write_checker_if.slave    bus,
    output logic [WIDTH-1:0]      expected,
    output logic [CNT_W-1:0]      term_idx,
    output logic [CNT_W-1:0]      pass_count,
    output logic [CNT_W-1:0]      fail_count,
    output logic                  done,
    output logic                  error,
    output logic                  overrun,
    output logic [ADDR_WIDTH-1:0] fail_adr,
    output logic [WIDTH-1:0]      fail_data,
    output logic                  dbg_state
);
    localparam logic [0:0] S_CHECK = 1'b0;
    localparam logic [0:0] S_DONE  = 1'b1;

    // Window bounds carry one extra bit so BASE_ADDR+NUM_TERMS == 2^ADDR_WIDTH does not wrap.
    localparam int AW1 = ADDR_WIDTH + 1;
    localparam logic [AW1-1:0]   WIN_LO   = AW1'(BASE_ADDR);
    localparam logic [AW1-1:0]   WIN_HI   = AW1'(BASE_ADDR + NUM_TERMS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TERMS - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] idx;
    logic [WIDTH-1:0] fa;
    logic [WIDTH-1:0] fb;

    logic           sample;
    logic           in_win;
    logic           at_slot;
    logic           pass_ev;
    logic           fail_ev;
    logic           advance;
    logic [AW1-1:0] adr_x;
    logic [AW1-1:0] slot_adr;

    always_comb begin
        sample   = en & bus.memwrite;
        adr_x    = {1'b0, bus.adr};
        slot_adr = WIN_LO + AW1'(idx);
        in_win   = (adr_x >= WIN_LO) && (adr_x < WIN_HI);
        at_slot  = (adr_x == slot_adr) && (bus.writedata == fa);
        pass_ev  = 1'b0;
        fail_ev  = 1'b0;
        advance  = 1'b0;
        if (sample && state == S_CHECK) begin
            if (in_win) begin
                advance = 1'b1;
                pass_ev = at_slot;
                fail_ev = !at_slot;
            end else begin
                fail_ev = (STRICT_WINDOW != 0);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_CHECK;
            idx        <= '0;
            fa         <= '0;
            fb         <= WIDTH'(1);
            pass_count <= '0;
            fail_count <= '0;
            error      <= 1'b0;
            overrun    <= 1'b0;
            fail_adr   <= '0;
            fail_data  <= '0;
        end else begin
            // Every in-window store consumes a term, so one bad store does not derail later checks.
            if (advance) begin
                idx <= idx + 1'b1;
                fa  <= fb;
                fb  <= fa + fb;
                if (idx == LAST_IDX) begin
                    state <= S_DONE;
                end
            end
            if (pass_ev) begin
                pass_count <= pass_count + 1'b1;
            end
            if (fail_ev) begin
                if (fail_count != '1) begin
                    fail_count <= fail_count + 1'b1;
                end
                error <= 1'b1;
                if (!error) begin
                    fail_adr  <= bus.adr;
                    fail_data <= bus.writedata;
                end
            end
            if (sample && state == S_DONE && in_win) begin
                overrun <= 1'b1;
            end
        end
    end

    assign expected  = fa;
    assign term_idx  = idx;
    assign done      = (state == S_DONE);
    assign dbg_state = state[0];
endmodule

// File: tb/tb_fib_write_checker.sv
// Bench for fib_write_checker: three configurations (default, 16 terms, strict window) share one
// snooped bus and are compared every store against a reference model built from the sequence rules.
module tb_fib_write_checker;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0;
    always #5 clk = ~clk;

    fib_write_checker_if #(.WIDTH(8), .ADDR_WIDTH(8)) bus_if ();

    // ---------------- DUTs ----------------
    logic [7:0] ex0, ex1, ex2, fa0, fa1, fa2, fd0, fd1, fd2;
    logic [3:0] ti0, pc0, fc0, ti2, pc2, fc2;
    logic [4:0] ti1, pc1, fc1;
    logic       dn0, dn1, dn2, er0, er1, er2, ov0, ov1, ov2, st0, st1, st2;

    fib_write_checker u0 (
        .clk(clk), .reset(reset), .en(en), .bus(bus_if),
        .expected(ex0), .term_idx(ti0), .pass_count(pc0), .fail_count(fc0),
        .done(dn0), .error(er0), .overrun(ov0), .fail_adr(fa0), .fail_data(fd0), .dbg_state(st0)
    );
    fib_write_checker #(.NUM_TERMS(16)) u1 (
        .clk(clk), .reset(reset), .en(en), .bus(bus_if),
        .expected(ex1), .term_idx(ti1), .pass_count(pc1), .fail_count(fc1),
        .done(dn1), .error(er1), .overrun(ov1), .fail_adr(fa1), .fail_data(fd1), .dbg_state(st1)
    );
    fib_write_checker #(.STRICT_WINDOW(1)) u2 (
        .clk(clk), .reset(reset), .en(en), .bus(bus_if),
        .expected(ex2), .term_idx(ti2), .pass_count(pc2), .fail_count(fc2),
        .done(dn2), .error(er2), .overrun(ov2), .fail_adr(fa2), .fail_data(fd2), .dbg_state(st2)
    );

    logic [63:0] obs [3];
    assign obs[0] = {21'd0, st0, fd0, fa0, ov0, er0, dn0, 1'b0, fc0, 1'b0, pc0, 1'b0, ti0, ex0};
    assign obs[1] = {21'd0, st1, fd1, fa1, ov1, er1, dn1, fc1, pc1, ti1, ex1};
    assign obs[2] = {21'd0, st2, fd2, fa2, ov2, er2, dn2, 1'b0, fc2, 1'b0, pc2, 1'b0, ti2, ex2};

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];             // F(0), F(1), ... mod 256
    int  cfg_nt   [3] = '{14, 16, 14};
    bit  cfg_strict [3] = '{1'b0, 1'b0, 1'b1};
    int  cfg_fmax [3] = '{15, 31, 15};
    int  m_idx [3], m_pass [3], m_fail [3], m_fadr [3], m_fdata [3];
    bit  m_done [3], m_err [3], m_ovr [3];
    int  checks = 0;
    int  errors = 0;

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_idx[k] = 0; m_pass[k] = 0; m_fail[k] = 0; m_fadr[k] = 0; m_fdata[k] = 0;
            m_done[k] = 1'b0; m_err[k] = 1'b0; m_ovr[k] = 1'b0;
        end
    endfunction

    function automatic void model_fail(int k, int a, int d);
        if (m_fail[k] < cfg_fmax[k]) m_fail[k]++;
        if (!m_err[k]) begin
            m_fadr[k] = a;
            m_fdata[k] = d;
        end
        m_err[k] = 1'b1;
    endfunction

    function automatic void model_store(int a, int d);
        for (int k = 0; k < 3; k++) begin
            bit inside_w;
            inside_w = (a >= 128) && (a < 128 + cfg_nt[k]);
            if (m_done[k]) begin
                if (inside_w) m_ovr[k] = 1'b1;
            end else if (!inside_w) begin
                if (cfg_strict[k]) model_fail(k, a, d);
            end else begin
                if (a == 128 + m_idx[k] && d == int'(exp_q[m_idx[k]])) m_pass[k]++;
                else model_fail(k, a, d);
                m_idx[k]++;
                if (m_idx[k] == cfg_nt[k]) m_done[k] = 1'b1;
            end
        end
    endfunction

    function automatic logic [63:0] model_vec(int k);
        logic [4:0] i5, p5, f5;
        logic [7:0] e8, a8, d8;
        i5 = 5'(m_idx[k]);
        p5 = 5'(m_pass[k]);
        f5 = 5'(m_fail[k]);
        e8 = exp_q[m_idx[k]];
        a8 = 8'(m_fadr[k]);
        d8 = 8'(m_fdata[k]);
        return {21'd0, m_done[k], d8, a8, m_ovr[k], m_err[k], m_done[k], f5, p5, i5, e8};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus_if.memwrite = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Returns 1 ns after the sampling edge; a following call still lands back-to-back.
    task automatic drive_store(input logic en_v, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        en = en_v;
        bus_if.memwrite = 1'b1;
        bus_if.adr = a;
        bus_if.writedata = d;
        @(posedge clk);
        if (en_v) model_store(int'(a), int'(d));
        #1 bus_if.memwrite = 1'b0;
    endtask

    task automatic drive_idle();
        @(negedge clk);
        bus_if.memwrite = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        #12;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== model_vec(k)) begin
                errors++;
                $display("FAIL reset dut%0d got %h want %h", k, obs[k], model_vec(k));
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_full_sequence();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive_store(1'b1, 8'(128 + i), exp_q[i]);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== model_vec(k)) begin
                    errors++;
                    $display("FAIL full_seq term%0d dut%0d got %h want %h", i, k, obs[k], model_vec(k));
                end
            end
        end
        checks++;
        if ({pc0, fc0, dn0, er0, ex0} !== {4'd14, 4'd0, 1'b1, 1'b0, 8'd121}) begin
            errors++;
            $display("FAIL full_seq_default got pass=%0d fail=%0d done=%b err=%b exp=%0d want 14 0 1 0 121",
                     pc0, fc0, dn0, er0, ex0);
        end
        checks++;
        if ({pc1, dn1, er1, ti1} !== {5'd16, 1'b1, 1'b0, 5'd16}) begin
            errors++;
            $display("FAIL full_seq_16 got pass=%0d done=%b err=%b idx=%0d want 16 1 0 16", pc1, dn1, er1, ti1);
        end
    endtask

    task automatic test_overrun_async_reset();
        drive_store(1'b1, 8'd141, 8'd233);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== model_vec(k)) begin
                errors++;
                $display("FAIL overrun dut%0d got %h want %h", k, obs[k], model_vec(k));
            end
        end
        checks++;
        if ({ov0, pc0} !== {1'b1, 4'd14}) begin
            errors++;
            $display("FAIL overrun_default got ovr=%b pass=%0d want 1 14", ov0, pc0);
        end
        #1 reset = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== 64'd0) begin
                errors++;
                $display("FAIL async_reset dut%0d got %h want 0", k, obs[k]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_bad_term();
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive_store(1'b1, 8'(128 + i), (i == 5) ? 8'd6 : exp_q[i]);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== model_vec(k)) begin
                    errors++;
                    $display("FAIL bad_term step%0d dut%0d got %h want %h", i, k, obs[k], model_vec(k));
                end
            end
        end
        checks++;
        if ({fc0, er0, fa0, fd0, pc0, dn0} !== {4'd1, 1'b1, 8'd133, 8'd6, 4'd13, 1'b1}) begin
            errors++;
            $display("FAIL bad_term_default got fail=%0d err=%b fadr=%0d fdata=%0d pass=%0d done=%b want 1 1 133 6 13 1",
                     fc0, er0, fa0, fd0, pc0, dn0);
        end
    endtask

    task automatic test_out_of_window();
        do_reset();
        for (int i = 0; i < 5; i++) drive_store(1'b1, 8'(128 + i), exp_q[i]);
        drive_store(1'b1, 8'd10, 8'h55);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== model_vec(k)) begin
                errors++;
                $display("FAIL oow dut%0d got %h want %h", k, obs[k], model_vec(k));
            end
        end
        checks++;
        if ({ti0, fc0, er0, ti2, fc2, fa2, fd2} !== {4'd5, 4'd0, 1'b0, 4'd5, 4'd1, 8'd10, 8'h55}) begin
            errors++;
            $display("FAIL oow_modes got idx0=%0d fail0=%0d err0=%b idx2=%0d fail2=%0d fadr2=%0d fdata2=%h want 5 0 0 5 1 10 55",
                     ti0, fc0, er0, ti2, fc2, fa2, fd2);
        end
        for (int i = 5; i < 14; i++) drive_store(1'b1, 8'(128 + i), exp_q[i]);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== model_vec(k)) begin
                errors++;
                $display("FAIL oow_finish dut%0d got %h want %h", k, obs[k], model_vec(k));
            end
        end
    endtask

    task automatic test_enable();
        do_reset();
        for (int i = 0; i < 3; i++) drive_store(1'b0, 8'(128 + i), exp_q[i]);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== model_vec(k)) begin
                errors++;
                $display("FAIL en_off dut%0d got %h want %h", k, obs[k], model_vec(k));
            end
        end
        drive_store(1'b1, 8'd128, 8'd0);
        checks++;
        if ({pc0, ti0, fc0} !== {4'd1, 4'd1, 4'd0}) begin
            errors++;
            $display("FAIL en_on got pass=%0d idx=%0d fail=%0d want 1 1 0", pc0, ti0, fc0);
        end
    endtask

    task automatic test_fail_saturate();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive_store(1'b1, 8'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== model_vec(k)) begin
                    errors++;
                    $display("FAIL saturate step%0d dut%0d got %h want %h", i, k, obs[k], model_vec(k));
                end
            end
        end
        checks++;
        if ({fc2, fc0, ti2} !== {4'd15, 4'd0, 4'd0}) begin
            errors++;
            $display("FAIL saturate_strict got fail2=%0d fail0=%0d idx2=%0d want 15 0 0", fc2, fc0, ti2);
        end
    endtask

    task automatic test_random();
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            for (int s = 0; s < 60; s++) begin
                int act;
                logic en_v;
                logic [7:0] a, d;
                act  = int'($urandom_range(0, 9));
                en_v = ($urandom_range(0, 7) != 0);
                a = 8'(128 + m_idx[0]);
                d = exp_q[m_idx[0]];
                case (act)
                    5: d = d ^ 8'($urandom_range(1, 255));
                    6: begin a = 8'(128 + $urandom_range(0, 15)); d = 8'($urandom_range(0, 255)); end
                    7: a = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 127)) : 8'($urandom_range(144, 255));
                    9: begin a = 8'($urandom_range(0, 255)); d = 8'($urandom_range(0, 255)); end
                    default: ;
                endcase
                if (act == 8) drive_idle();
                else drive_store(en_v, a, d);
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (obs[k] !== model_vec(k)) begin
                        errors++;
                        $display("FAIL random ep%0d step%0d dut%0d got %h want %h", ep, s, k, obs[k], model_vec(k));
                    end
                end
            end
        end
    endtask

    // ---------------- main ----------------
    initial begin
        bus_if.memwrite  = 1'b0;
        bus_if.adr       = '0;
        bus_if.writedata = '0;
        exp_q.push_back(8'd0);
        exp_q.push_back(8'd1);
        for (int i = 2; i < 20; i++) exp_q.push_back(8'(exp_q[i-1] + exp_q[i-2]));

        test_reset();
        test_full_sequence();
        test_overrun_async_reset();
        test_bad_term();
        test_out_of_window();
        test_enable();
        test_fail_saturate();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
